// File: rtl/isi_lane_pattern_gen_pkg.sv
// isi_pkg: shared FSM type, default taps and the skew clamp helper
// for the multi-lane ISI pattern generator.
package isi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } isi_state_e;

   // PRBS7 = x^7 + x^6 + 1
   localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

   function automatic int clamp_dly(input int dly, input int max_dly);
      return (dly > max_dly) ? max_dly : dly;
   endfunction

endpackage

// File: rtl/isi_lane_pattern_gen_if.sv
// Configuration handshake bundle: per-lane seed, taps, skew and
// inversion offered with a valid/ready pair.
interface isi_lane_pattern_gen_if #(
   parameter int LANES  = 5,
   parameter int LFSR_W = 7,
   parameter int DLY_W  = 3
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [LANES*LFSR_W-1:0] cfg_seed;
   logic [LANES*LFSR_W-1:0] cfg_taps;
   logic [LANES*DLY_W-1:0]  cfg_delay;
   logic [LANES-1:0]        cfg_invert;

   modport master (
      output cfg_valid, cfg_seed, cfg_taps,
      output cfg_delay, cfg_invert,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_seed, cfg_taps,
      input  cfg_delay, cfg_invert,
      output cfg_ready
   );
endinterface

// File: rtl/isi_lfsr_lane.sv
// One pattern lane: Fibonacci LFSR, skew delay line and output
// inversion. The output bit is combinational; the top registers it.
module isi_lfsr_lane #(
   parameter int LFSR_W  = 7,
   parameter int MAX_DLY = 4,
   parameter int DLY_W   = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [LFSR_W-1:0] seed,
   input  logic [LFSR_W-1:0] taps,
   input  logic [DLY_W-1:0]  dly,
   input  logic              inv,
   output logic [LFSR_W-1:0] state,
   output logic              bit_out
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [MAX_DLY:1]  line_q, line_d;
   logic [MAX_DLY:0]  tapv;
   logic              sel;

   // tapv[0] is the live lane bit, tapv[j] the bit from j steps ago
   assign tapv  = {line_q, lfsr_q[LFSR_W-1]};
   assign state = lfsr_q;

   always_comb begin
      lfsr_d = lfsr_q;
      line_d = line_q;
      if (load) begin
         lfsr_d = seed;
         line_d = '0;
      end else if (step) begin
         lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & taps)};
         line_d = tapv[MAX_DLY-1:0];
      end
   end

   always_comb begin
      sel = tapv[0];
      for (int j = 1; j <= MAX_DLY; j++) begin
         if (dly == DLY_W'(j)) sel = tapv[j];
      end
   end

   assign bit_out = sel ^ inv;

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= '0;
         line_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         line_q <= line_d;
      end
   end

endmodule

// File: rtl/isi_lane_pattern_gen.sv
// Multi-lane PRBS source: FSM, config handshake, run counter and
// lane-0 wrap detect around LANES independent LFSR lanes.
module isi_lane_pattern_gen
   import isi_pkg::*;
#(
   parameter int LANES   = 5,
   parameter int LFSR_W  = 7,
   parameter int MAX_DLY = 4,
   parameter int DLY_W   = 3,
   parameter int CNT_W   = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   isi_lane_pattern_gen_if.slave   cfg,
   output logic [LANES-1:0]        lout,
   output logic                    lout_valid,
   output logic [LANES*LFSR_W-1:0] lfsr_state,
   output logic [CNT_W-1:0]        run_count,
   output logic                    wrap0,
   output logic                    seed_fixed
);

   localparam int PW = (MAX_DLY > 1) ? $clog2(MAX_DLY + 1) : 1;

   isi_state_e state_q, state_d;
   logic [PW-1:0]           prime_q, prime_d;
   logic [CNT_W-1:0]        run_q, run_d;
   logic [LANES-1:0]        lout_q, lout_d;
   logic                    lv_q, lv_d;
   logic                    wrap_q, wrap_d;
   logic                    fixed_q, fixed_d;
   logic [LFSR_W-1:0]       seed0_q, seed0_d;
   logic [LANES*LFSR_W-1:0] taps_q, taps_d;
   logic [LANES*DLY_W-1:0]  dly_q, dly_d;
   logic [LANES-1:0]        inv_q, inv_d;

   logic                    ready, xfer, step, any_zero;
   logic [LANES*LFSR_W-1:0] seed_fx;
   logic [LANES*DLY_W-1:0]  dly_cl;
   logic [LANES-1:0]        lane_out;
   logic [LFSR_W-1:0]       nxt0;

   assign ready         = (state_q != ST_PRIME);
   assign cfg.cfg_ready = ready;
   assign xfer          = cfg.cfg_valid && ready;
   assign step          = enable && !xfer && (state_q != ST_IDLE);

   // zero seeds would lock the LFSR, so they load as 1
   always_comb begin
      seed_fx  = cfg.cfg_seed;
      dly_cl   = '0;
      any_zero = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (cfg.cfg_seed[i*LFSR_W +: LFSR_W] == '0) begin
            seed_fx[i*LFSR_W +: LFSR_W] = LFSR_W'(1);
            any_zero = 1'b1;
         end
         dly_cl[i*DLY_W +: DLY_W] = DLY_W'(clamp_dly(
            int'(cfg.cfg_delay[i*DLY_W +: DLY_W]), MAX_DLY));
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      isi_lfsr_lane #(
         .LFSR_W  (LFSR_W),
         .MAX_DLY (MAX_DLY),
         .DLY_W   (DLY_W)
      ) u_lane (
         .clock   (clock),
         .reset   (reset),
         .load    (xfer),
         .step    (step),
         .seed    (seed_fx[i*LFSR_W +: LFSR_W]),
         .taps    (taps_q[i*LFSR_W +: LFSR_W]),
         .dly     (dly_q[i*DLY_W +: DLY_W]),
         .inv     (inv_q[i]),
         .state   (lfsr_state[i*LFSR_W +: LFSR_W]),
         .bit_out (lane_out[i])
      );
   end

   assign nxt0 = {lfsr_state[LFSR_W-2:0],
                  ^(lfsr_state[LFSR_W-1:0] & taps_q[LFSR_W-1:0])};

   always_comb begin
      state_d = state_q;
      prime_d = prime_q;
      unique case (state_q)
         ST_IDLE: ;
         ST_PRIME: begin
            if (enable) begin
               prime_d = prime_q + 1'b1;
               if (prime_q == PW'(MAX_DLY - 1)) state_d = ST_RUN;
            end
         end
         ST_RUN: ;
         default: state_d = ST_IDLE;
      endcase
      if (xfer) begin
         state_d = ST_PRIME;
         prime_d = '0;
      end
   end

   always_comb begin
      lout_d  = lout_q;
      lv_d    = lv_q;
      run_d   = run_q;
      wrap_d  = 1'b0;
      fixed_d = fixed_q;
      seed0_d = seed0_q;
      taps_d  = taps_q;
      dly_d   = dly_q;
      inv_d   = inv_q;
      if (xfer) begin
         lout_d  = '0;
         lv_d    = 1'b0;
         run_d   = '0;
         fixed_d = any_zero;
         seed0_d = seed_fx[LFSR_W-1:0];
         taps_d  = cfg.cfg_taps;
         dly_d   = dly_cl;
         inv_d   = cfg.cfg_invert;
      end else if (enable) begin
         lout_d = (state_q == ST_RUN) ? lane_out : '0;
         lv_d   = (state_q == ST_RUN);
         if (state_q == ST_RUN) begin
            run_d  = run_q + 1'b1;
            wrap_d = (nxt0 == seed0_q);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         prime_q <= '0;
         run_q   <= '0;
         lout_q  <= '0;
         lv_q    <= 1'b0;
         wrap_q  <= 1'b0;
         fixed_q <= 1'b0;
         seed0_q <= '0;
         taps_q  <= '0;
         dly_q   <= '0;
         inv_q   <= '0;
      end else begin
         state_q <= state_d;
         prime_q <= prime_d;
         run_q   <= run_d;
         lout_q  <= lout_d;
         lv_q    <= lv_d;
         wrap_q  <= wrap_d;
         fixed_q <= fixed_d;
         seed0_q <= seed0_d;
         taps_q  <= taps_d;
         dly_q   <= dly_d;
         inv_q   <= inv_d;
      end
   end

   assign lout       = lout_q;
   assign lout_valid = lv_q;
   assign run_count  = run_q;
   assign wrap0      = wrap_q;
   assign seed_fixed = fixed_q;

endmodule

// File: tb/tb_isi_lane_pattern_gen.sv
// Directed bench for isi_lane_pattern_gen with 4-bit LFSRs
// (taps 1001, seed 0001, period 15) on five lanes.
module tb_isi_lane_pattern_gen;

   localparam int LANES   = 5;
   localparam int LFSR_W  = 4;
   localparam int MAX_DLY = 4;
   localparam int DLY_W   = 3;
   localparam int CNT_W   = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;

   logic [LANES-1:0]        lout;
   logic                    lout_valid;
   logic [LANES*LFSR_W-1:0] lfsr_state;
   logic [CNT_W-1:0]        run_count;
   logic                    wrap0;
   logic                    seed_fixed;

   int checks = 0;
   int errors = 0;

   // hand-stepped states from seed 0001, taps 1001
   logic [3:0] st_tab [15];
   int         cur_eff [5];
   logic [4:0] cur_inv;

   isi_lane_pattern_gen_if #(
      .LANES(LANES), .LFSR_W(LFSR_W), .DLY_W(DLY_W)
   ) cfg ();

   isi_lane_pattern_gen #(
      .LANES(LANES), .LFSR_W(LFSR_W), .MAX_DLY(MAX_DLY),
      .DLY_W(DLY_W), .CNT_W(CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .cfg        (cfg.slave),
      .lout       (lout),
      .lout_valid (lout_valid),
      .lfsr_state (lfsr_state),
      .run_count  (run_count),
      .wrap0      (wrap0),
      .seed_fixed (seed_fixed)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // first valid cycle is m=1; lane with delay d shows bit 3+m-d
   function automatic logic [4:0] exp_lout(input int m);
      logic [4:0] r;
      int idx;
      for (int i = 0; i < 5; i++) begin
         idx  = 3 + m - cur_eff[i];
         r[i] = st_tab[idx % 15][3] ^ cur_inv[i];
      end
      return r;
   endfunction

   task automatic drive_cfg_a();
      cfg.cfg_seed   = {4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
      cfg.cfg_taps   = {5{4'b1001}};
      cfg.cfg_delay  = {3'd3, 3'd7, 3'd2, 3'd0, 3'd0};
      cfg.cfg_invert = 5'b01000;
      cur_eff = '{0, 0, 2, 4, 3};
      cur_inv = 5'b01000;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b0;
      cfg.cfg_valid = 1'b0;
      drive_cfg_a();
      tick();
      tick();
      checks++;
      if ({cfg.cfg_ready, lout, lout_valid, wrap0, seed_fixed}
          !== {1'b1, 5'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_flags got rdy=%b lout=%b lv=%b w=%b sf=%b",
                  cfg.cfg_ready, lout, lout_valid, wrap0, seed_fixed);
      end
      checks++;
      if (lfsr_state !== '0 || run_count !== '0) begin
         errors++;
         $display("FAIL reset_regs got lfsr=%h cnt=%0d exp 0 0",
                  lfsr_state, run_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_prime_run();
      enable = 1'b1;
      drive_cfg_a();
      cfg.cfg_valid = 1'b1;
      tick();
      checks++;
      if (cfg.cfg_ready !== 1'b0 || lfsr_state !== {5{4'h1}}
          || seed_fixed !== 1'b1 || lout_valid !== 1'b0) begin
         errors++;
         $display("FAIL load got rdy=%b lfsr=%h sf=%b lv=%b",
                  cfg.cfg_ready, lfsr_state, seed_fixed, lout_valid);
      end
      // offer a different config during PRIME; must be ignored
      cfg.cfg_seed  = {5{4'hF}};
      cfg.cfg_delay = '0;
      for (int p = 1; p <= 4; p++) begin
         tick();
         checks++;
         if (lfsr_state !== {5{st_tab[p]}} || lout_valid !== 1'b0
             || lout !== 5'b0) begin
            errors++;
            $display("FAIL prime%0d got lfsr=%h lv=%b lout=%b exp lfsr=%h",
                     p, lfsr_state, lout_valid, lout, {5{st_tab[p]}});
         end
      end
      cfg.cfg_valid = 1'b0;
      drive_cfg_a();
      for (int m = 1; m <= 32; m++) begin
         tick();
         checks++;
         if (lout_valid !== 1'b1 || lout !== exp_lout(m)) begin
            errors++;
            $display("FAIL run_lout m=%0d got lv=%b lout=%b exp %b",
                     m, lout_valid, lout, exp_lout(m));
         end
         checks++;
         if (run_count !== CNT_W'(m)
             || lfsr_state !== {5{st_tab[(4 + m) % 15]}}) begin
            errors++;
            $display("FAIL run_state m=%0d got cnt=%0d lfsr=%h",
                     m, run_count, lfsr_state);
         end
         checks++;
         if (wrap0 !== (m == 11 || m == 26)) begin
            errors++;
            $display("FAIL wrap0 m=%0d got %b", m, wrap0);
         end
      end
   endtask

   task automatic test_reconfig_freeze();
      cfg.cfg_seed   = {5{4'h1}};
      cfg.cfg_taps   = {5{4'b1001}};
      cfg.cfg_delay  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      cfg.cfg_invert = 5'b0;
      cur_eff = '{0, 1, 2, 3, 4};
      cur_inv = 5'b0;
      checks++;
      if (cfg.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL run_ready got %b exp 1", cfg.cfg_ready);
      end
      cfg.cfg_valid = 1'b1;
      tick();
      cfg.cfg_valid = 1'b0;
      checks++;
      if (lout_valid !== 1'b0 || run_count !== '0 || seed_fixed !== 1'b0
          || lout !== 5'b0 || lfsr_state !== {5{4'h1}}) begin
         errors++;
         $display("FAIL reconfig got lv=%b cnt=%0d sf=%b lout=%b lfsr=%h",
                  lout_valid, run_count, seed_fixed, lout, lfsr_state);
      end
      tick();
      tick();
      enable = 1'b0;
      for (int f = 0; f < 3; f++) begin
         tick();
         checks++;
         if (lfsr_state !== {5{4'h7}} || lout_valid !== 1'b0) begin
            errors++;
            $display("FAIL prime_freeze%0d got lfsr=%h lv=%b",
                     f, lfsr_state, lout_valid);
         end
      end
      enable = 1'b1;
      tick();
      tick();
      checks++;
      if (lout_valid !== 1'b0) begin
         errors++;
         $display("FAIL prime_extend got lv=%b exp 0", lout_valid);
      end
      for (int m = 1; m <= 3; m++) begin
         tick();
         checks++;
         if (lout_valid !== 1'b1 || lout !== exp_lout(m)
             || run_count !== CNT_W'(m)) begin
            errors++;
            $display("FAIL skew m=%0d got lv=%b lout=%b cnt=%0d exp %b",
                     m, lout_valid, lout, run_count, exp_lout(m));
         end
      end
      enable = 1'b0;
      for (int f = 0; f < 3; f++) begin
         tick();
         checks++;
         if (lout !== exp_lout(3) || run_count !== CNT_W'(3)
             || lfsr_state !== {5{st_tab[7]}} || wrap0 !== 1'b0
             || lout_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_freeze%0d got lout=%b cnt=%0d lfsr=%h w=%b",
                     f, lout, run_count, lfsr_state, wrap0);
         end
      end
      enable = 1'b1;
      tick();
      checks++;
      if (lout !== exp_lout(4) || run_count !== CNT_W'(4)) begin
         errors++;
         $display("FAIL resume got lout=%b cnt=%0d exp %b 4",
                  lout, run_count, exp_lout(4));
      end
   endtask

   task automatic test_reset_mid_run();
      tick();
      tick();
      reset = 1'b1;
      cfg.cfg_seed  = {5{4'h0}};
      cfg.cfg_valid = 1'b1;
      tick();
      checks++;
      if ({cfg.cfg_ready, lout, lout_valid, wrap0, seed_fixed}
          !== {1'b1, 5'b0, 1'b0, 1'b0, 1'b0}
          || lfsr_state !== '0 || run_count !== '0) begin
         errors++;
         $display("FAIL mid_reset got rdy=%b lout=%b lv=%b sf=%b lfsr=%h cnt=%0d",
                  cfg.cfg_ready, lout, lout_valid, seed_fixed,
                  lfsr_state, run_count);
      end
      reset = 1'b0;
      cfg.cfg_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (lfsr_state !== '0 || lout_valid !== 1'b0
          || cfg.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_after got lfsr=%h lv=%b rdy=%b",
                  lfsr_state, lout_valid, cfg.cfg_ready);
      end
   endtask

   task automatic test_xfer_disabled();
      enable = 1'b0;
      drive_cfg_a();
      cfg.cfg_valid = 1'b1;
      tick();
      cfg.cfg_valid = 1'b0;
      checks++;
      if (cfg.cfg_ready !== 1'b0 || lfsr_state !== {5{4'h1}}
          || seed_fixed !== 1'b1) begin
         errors++;
         $display("FAIL xfer_disabled got rdy=%b lfsr=%h sf=%b",
                  cfg.cfg_ready, lfsr_state, seed_fixed);
      end
   endtask

   initial begin
      st_tab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
      test_reset();
      test_prime_run();
      test_reconfig_freeze();
      test_reset_mid_run();
      test_xfer_disabled();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/isi_lane_pattern_gen.md
# isi_lane_pattern_gen

Parametrised multi-lane PRBS source for ISI characterisation. Each of LANES channels runs an independent Fibonacci LFSR with runtime-programmable polynomial, seed, inversion and skew delay (0..MAX_DLY cycles). Outputs stay gated until every delay line holds valid data. It replaces the fixed five-lane, fixed-delay generator and drives the lane serialisers and checker bench directly.

## Interface
- LANES, 5, number of output lanes
- LFSR_W, 7, LFSR register width (all lanes)
- MAX_DLY, 4, maximum per-lane skew in cycles (≥1)
- DLY_W, 3, width of one delay field; must satisfy 2^DLY_W > MAX_DLY
- CNT_W, 16, width of run-cycle counter
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  advance enable; low freezes all sequential state except the FSM response to reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accept
- cfg_seed  in  LANES*LFSR_W  per-lane seed, lane i at [i*LFSR_W +: LFSR_W]
- cfg_taps  in  LANES*LFSR_W  per-lane feedback tap mask
- cfg_delay  in  LANES*DLY_W  per-lane skew
- cfg_invert  in  LANES  per-lane output inversion
- lout  out  LANES  serial pattern bit per lane
- lout_valid  out  1  lout is meaningful
- lfsr_state  out  LANES*LFSR_W  current LFSR registers
- run_count  out  CNT_W  enabled RUN cycles since last configuration
- wrap0  out  1  one-cycle pulse: lane 0 LFSR returned to its seed
- seed_fixed  out  1  sticky: a zero seed was substituted

## Operation
- FSM states IDLE, PRIME, RUN. Reset → IDLE.
- Handshake: transfer when cfg_valid && cfg_ready. cfg_ready = 1 in IDLE and RUN, 0 in PRIME. Configuration registered on transfer; inputs may change afterwards.
- Transfer (from IDLE or RUN) → PRIME; LFSRs load seeds, delay lines clear, prime counter = 0, run_count = 0, seed_fixed recomputed.
- Zero seed: lane loads 1 instead; seed_fixed set, cleared only by next transfer or reset.
- LFSR step (enable=1, PRIME or RUN): fb = XOR-reduce(state & taps); state ← {state[LFSR_W-2:0], fb}; lane bit = state[LFSR_W-1] before the step.
- Delay line: MAX_DLY-stage shift register per lane, shifting the lane bit on each step. lout[i] = (cfg_delay[i]==0 ? lane bit : stage cfg_delay[i]) XOR cfg_invert[i]. cfg_delay values > MAX_DLY are clamped to MAX_DLY.
- PRIME: lasts MAX_DLY enabled cycles, then RUN. lout forced 0, lout_valid = 0.
- RUN: lout_valid = 1; run_count increments per enabled cycle, wraps to 0 at 2^CNT_W.
- wrap0: asserted in RUN for the enabled cycle in which lane 0 state equals its loaded seed after at least one step.
- enable = 0: LFSRs, delay lines, counters, prime counter hold; lout holds; wrap0 = 0; handshake still active.
- Transfer and reset same cycle: reset wins.

## Timing
- Reset values: cfg_ready 1, lout 0, lout_valid 0, lfsr_state 0, run_count 0, wrap0 0, seed_fixed 0; configuration registers 0.
- Transfer at edge N → PRIME from N+1; with enable held high, lout_valid rises at N+1+MAX_DLY.
- First valid lout on lane with delay d = lane bit index MAX_DLY−d (index 0 = seed MSB); lanes of equal seed/taps differ by exactly their delay difference.
- All outputs registered; no combinational path from cfg_* to lout.
- Reset mid-PRIME or mid-RUN: IDLE on next edge, all outputs at reset values.

## Structure
- Package isi_pkg: FSM state enum, default tap constants (e.g. PRBS7 = x^7+x^6+1), delay clamp function.
- Sub-module isi_lfsr_lane: one LFSR + delay line + inversion, instanced LANES times via generate; top holds FSM, handshake, counters, wrap0.

## Test plan
- LFSR_W=4, MAX_DLY=4, lane 0 taps 4'b1001 seed 4'b0001 delay 0: lout_valid at transfer+5; lout = 1,1,1,0,…; period 15; wrap0 every 15 enabled RUN cycles.
- Same seed/taps on lane 2 with delay 2: first valid bits 0,1,1,1; lane 2 equals lane 0 shifted by 2 cycles.
- Seed 0 on lane 1: seed_fixed = 1, lane 1 loads 4'b0001, runs identically to lane 0; next transfer with non-zero seed clears it.
- enable low for 3 cycles in PRIME and RUN: lfsr_state, lout, run_count frozen; lout_valid timing extended by 3.
- Reconfigure in RUN (cfg_ready=1): lout_valid drops next cycle, run_count = 0, new pattern after MAX_DLY; cfg_valid in PRIME not accepted.
- Reset asserted mid-RUN concurrent with cfg_valid: next cycle IDLE, all outputs at reset values, configuration not taken.
